// File: rtl/usb_line_state_decoder_if.sv
// Pad-side and link-side signals of the USB line state decoder.
// master: the pad/stimulus side driving D+/D-; slave: the decoder itself.
interface usb_line_state_decoder_if;
  logic       usb_dp;
  logic       usb_dn;
  logic [1:0] usb_line_state;
  logic       line_se0;
  logic       line_j;
  logic       line_k;
  logic       line_se1;
  logic       state_chg;
  logic       bus_reset;
  logic       bus_idle;

  modport master (
    output usb_dp, usb_dn,
    input  usb_line_state, line_se0, line_j, line_k, line_se1,
           state_chg, bus_reset, bus_idle
  );

  modport slave (
    input  usb_dp, usb_dn,
    output usb_line_state, line_se0, line_j, line_k, line_se1,
           state_chg, bus_reset, bus_idle
  );
endinterface

// File: rtl/usb_line_state_decoder.sv
// USB line state decoder: synchronises raw D+/D-, deglitches the pair,
// reports SE0/J/K/SE1 and flags long SE0 (bus reset) and long J (bus idle).
module usb_line_state_decoder #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 2,
  parameter int RESET_CYCLES  = 120,
  parameter int IDLE_CYCLES   = 7
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  usb_line_state_decoder_if.slave      io_bus
);

  localparam int RUN_MAX = (RESET_CYCLES > IDLE_CYCLES) ? RESET_CYCLES : IDLE_CYCLES;
  localparam int RUN_W   = $clog2(RUN_MAX + 1);
  localparam int CNT_W   = $clog2(FILTER_CYCLES + 1);

  localparam logic [1:0] LS_SE0 = 2'b00;
  localparam logic [1:0] LS_J   = 2'b10;
  localparam logic [1:0] LS_K   = 2'b01;
  localparam logic [1:0] LS_SE1 = 2'b11;

  logic [SYNC_STAGES-1:0] r_dp_sync, r_dn_sync;
  logic [1:0]             r_prev;
  logic [CNT_W-1:0]       r_cnt;
  logic [1:0]             r_state;
  logic                   r_chg;
  logic [RUN_W-1:0]       r_run;
  logic                   r_bus_reset;
  logic                   r_bus_idle;

  logic [1:0]             w_pair;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic                   w_accept;
  logic [RUN_W-1:0]       w_run_nxt;

  assign w_pair = {r_dp_sync[SYNC_STAGES-1], r_dn_sync[SYNC_STAGES-1]};

  // Plain flop chain per pin; nothing may sit between stages.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_dp_sync <= '0;
      r_dn_sync <= '0;
    end else begin
      r_dp_sync <= {r_dp_sync[SYNC_STAGES-2:0], io_bus.usb_dp};
      r_dn_sync <= {r_dn_sync[SYNC_STAGES-2:0], io_bus.usb_dn};
    end
  end

  // Stability count of the synchronised pair and saturating run length.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_pair != r_prev)
      w_cnt_nxt = CNT_W'(1);
    else if (r_cnt < CNT_W'(FILTER_CYCLES))
      w_cnt_nxt = r_cnt + CNT_W'(1);
    w_accept = (w_cnt_nxt == CNT_W'(FILTER_CYCLES)) && (w_pair != r_state);
    w_run_nxt = r_run;
    if (r_run < RUN_W'(RUN_MAX))
      w_run_nxt = r_run + RUN_W'(1);
  end

  // Filtered state, change pulse, run length and long-state flags.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_prev      <= '0;
      r_cnt       <= '0;
      r_state     <= LS_SE0;
      r_chg       <= 1'b0;
      r_run       <= '0;
      r_bus_reset <= 1'b0;
      r_bus_idle  <= 1'b0;
    end else begin
      r_prev <= w_pair;
      r_cnt  <= w_cnt_nxt;
      r_chg  <= w_accept;
      if (w_accept) begin
        r_state     <= w_pair;
        r_run       <= '0;
        r_bus_reset <= 1'b0;
        r_bus_idle  <= 1'b0;
      end else begin
        r_run       <= w_run_nxt;
        r_bus_reset <= (r_state == LS_SE0) && (w_run_nxt >= RUN_W'(RESET_CYCLES));
        r_bus_idle  <= (r_state == LS_J)   && (w_run_nxt >= RUN_W'(IDLE_CYCLES));
      end
    end
  end

  assign io_bus.usb_line_state = r_state;
  assign io_bus.line_se0       = (r_state == LS_SE0);
  assign io_bus.line_j         = (r_state == LS_J);
  assign io_bus.line_k         = (r_state == LS_K);
  assign io_bus.line_se1       = (r_state == LS_SE1);
  assign io_bus.state_chg      = r_chg;
  assign io_bus.bus_reset      = r_bus_reset;
  assign io_bus.bus_idle       = r_bus_idle;

endmodule

// File: tb/tb_usb_line_state_decoder.sv
// Bench for usb_line_state_decoder: directed scenarios plus random pin
// activity, compared every cycle against a sample-history reference model.
module tb_usb_line_state_decoder;
  localparam int S    = 2;
  localparam int F    = 2;
  localparam int RSTC = 120;
  localparam int IDLC = 7;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errs   = 0;
  int   nchg   = 0;

  usb_line_state_decoder_if ifc ();

  usb_line_state_decoder #(
    .SYNC_STAGES(S), .FILTER_CYCLES(F), .RESET_CYCLES(RSTC), .IDLE_CYCLES(IDLC)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (ifc.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the filtered state is whatever pair has been seen for
  // F consecutive samples, S samples late; long-state flags from the time
  // elapsed since the last accepted change.
  logic [1:0] hist[$];
  int         t = 0;
  int         t_last = 0;
  logic [1:0] m_state = 2'b00;
  bit         m_chg = 0, m_rst = 0, m_idle = 0;

  always @(posedge clk) begin
    t++;
    if (!rst_n) begin
      hist.delete();
      for (int k = 0; k < S + F; k++) hist.push_back(2'b00);
      m_state = 2'b00; m_chg = 0; m_rst = 0; m_idle = 0; t_last = t;
    end else begin
      int sz;
      logic [1:0] cur;
      bit stable;
      hist.push_back({ifc.usb_dp, ifc.usb_dn});
      if (hist.size() > 32) void'(hist.pop_front());
      sz = hist.size();
      cur = hist[sz-1-S];
      stable = 1;
      for (int k = 0; k < F; k++)
        if (hist[sz-1-S-k] != cur) stable = 0;
      m_chg = stable && (cur != m_state);
      if (m_chg) begin
        m_state = cur;
        t_last  = t;
      end
      m_rst  = (m_state == 2'b00) && ((t - t_last) >= RSTC);
      m_idle = (m_state == 2'b10) && ((t - t_last) >= IDLC);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("line_state", int'(ifc.usb_line_state), int'(m_state));
    chk("state_chg",  int'(ifc.state_chg),      int'(m_chg));
    chk("bus_reset",  int'(ifc.bus_reset),      int'(m_rst));
    chk("bus_idle",   int'(ifc.bus_idle),       int'(m_idle));
    chk("line_se0",   int'(ifc.line_se0),       int'(m_state == 2'b00));
    chk("line_j",     int'(ifc.line_j),         int'(m_state == 2'b10));
    chk("line_k",     int'(ifc.line_k),         int'(m_state == 2'b01));
    chk("line_se1",   int'(ifc.line_se1),       int'(m_state == 2'b11));
    if (ifc.state_chg) nchg++;
  end

  task automatic hold(input logic dp, input logic dn, input int n);
    ifc.usb_dp = dp;
    ifc.usb_dn = dn;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int base;
    ifc.usb_dp = 1'b1;
    ifc.usb_dn = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_state", int'(ifc.usb_line_state), 0);
    chk("rst_se0",   int'(ifc.line_se0), 1);
    chk("rst_breset", int'(ifc.bus_reset), 0);
    chk("rst_bidle",  int'(ifc.bus_idle), 0);
    rst_n = 1'b1;

    // Decode sequence
    base = nchg;
    hold(0, 0, 10); #1; chk("dec_se0", int'(ifc.usb_line_state), 0);
    hold(1, 0, 3);  #1; chk("lat_j_early", int'(ifc.usb_line_state), 0);
    hold(1, 0, 7);  #1; chk("dec_j",   int'(ifc.usb_line_state), 2);
    hold(0, 1, 10); #1; chk("dec_k",   int'(ifc.usb_line_state), 1);
    hold(1, 1, 10); #1; chk("dec_se1", int'(ifc.usb_line_state), 3);
    chk("dec_pulses", nchg - base, 3);

    // Glitch rejection then a 2-clock K that is accepted
    hold(1, 0, 10);
    base = nchg;
    hold(0, 1, 1);
    hold(1, 0, 10); #1;
    chk("glitch1_state", int'(ifc.usb_line_state), 2);
    chk("glitch1_pulses", nchg - base, 0);
    hold(0, 1, 2);
    hold(0, 1, 0); repeat (2) @(negedge clk); #1;
    chk("glitch2_state", int'(ifc.usb_line_state), 1);
    hold(1, 0, 10);

    // Bus reset then idle
    hold(0, 0, 125); #1;
    chk("breset_hi", int'(ifc.bus_reset), 1);
    hold(1, 0, 14); #1;
    chk("breset_lo", int'(ifc.bus_reset), 0);
    chk("bidle_hi",  int'(ifc.bus_idle), 1);

    // Skewed J->K through a one-clock SE1
    base = nchg;
    hold(1, 1, 1);
    hold(0, 1, 10); #1;
    chk("skew_state",  int'(ifc.usb_line_state), 1);
    chk("skew_pulses", nchg - base, 1);

    // Mid-operation reset during an SE0 run
    hold(0, 0, 100);
    rst_n = 1'b0;
    hold(0, 0, 3);
    rst_n = 1'b1;
    hold(0, 0, 110); #1;
    chk("midrst_lo", int'(ifc.bus_reset), 0);
    hold(0, 0, 15); #1;
    chk("midrst_hi", int'(ifc.bus_reset), 1);

    // Random pin activity with occasional long holds
    for (int i = 0; i < 400; i++) begin
      logic [1:0] p;
      int len;
      p = 2'($urandom_range(0, 3));
      len = ($urandom_range(0, 19) == 0) ? $urandom_range(8, 130) : $urandom_range(1, 4);
      if ($urandom_range(0, 99) == 0) begin
        rst_n = 1'b0;
        hold(p[1], p[0], 2);
        rst_n = 1'b1;
      end
      hold(p[1], p[0], len);
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
